dispatch_stall_ctrl: RTL and testbench
======================================

DISPATCH_STALL_CTRL -- requirements
Module: dispatch_stall_ctrl

Interface
REQ-001 SHALL have parameter MAX_BR, default 2, max unresolved conditional branches in flight (1..15).
REQ-002 SHALL have parameter RECOVER_CYC, default 2, post-flush stall cycles (1..15).
REQ-003 SHALL have one clock, clk, and one reset, rst; rst is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  async active-high reset.
REQ-006 branch  input  1  conditional branch dispatched this cycle.
REQ-007 jalr  input  1  JALR dispatched this cycle.
REQ-008 branch_solved  input  1  one branch resolved this cycle.
REQ-009 jalr_solved  input  1  pending JALR target resolved.
REQ-010 ifq_empty  input  1  instruction fetch queue empty.
REQ-011 flush  input  1  mispredict/redirect flush pulse.
REQ-012 nstall  output  1  dispatch permitted (active-high).
REQ-013 stall_cause  output  2  0 none, 1 branch limit, 2 jalr, 3 ifq/recover.
REQ-014 br_cnt  output  4  unresolved branches in flight.
REQ-015 stall_cycles  output  32  saturating count of stalled cycles (see Configuration).

Function
REQ-016 SHALL hold FSM states NORMAL, WAIT_JALR, WAIT_IFQ, RECOVER; plus branch counter br_cnt, recover counter rc.
REQ-017 nstall SHALL be combinational: 1 iff state==NORMAL and br_cnt<MAX_BR.
REQ-018 branch/jalr SHALL be accepted only in cycles where nstall==1; otherwise ignored.
REQ-019 Accepted branch SHALL increment br_cnt next cycle; branch_solved with br_cnt>0 SHALL decrement; both same cycle SHALL leave br_cnt unchanged.
REQ-020 branch_solved with br_cnt==0 SHALL be ignored (no underflow); br_cnt SHALL never exceed MAX_BR.
REQ-021 NORMAL transitions, priority order: accepted jalr -> WAIT_JALR; else ifq_empty -> WAIT_IFQ; else stay.
REQ-022 Accepted branch and jalr in same cycle SHALL both take effect (count + WAIT_JALR).
REQ-023 WAIT_JALR -> NORMAL on jalr_solved; branch_solved continues to decrement br_cnt in any state.
REQ-024 WAIT_IFQ -> NORMAL on first cycle ifq_empty==0.
REQ-025 flush SHALL override all: br_cnt<=0, rc<=RECOVER_CYC-1, state<=RECOVER, regardless of current state or other inputs.
REQ-026 RECOVER: decrement rc each cycle; when rc==0 -> WAIT_IFQ if ifq_empty else NORMAL; flush in RECOVER SHALL restart rc.
REQ-027 stall_cause priority: state RECOVER/WAIT_IFQ ->3; WAIT_JALR ->2; br_cnt==MAX_BR ->1; else 0.

Reset
REQ-028 rst SHALL force state=NORMAL, br_cnt=0, rc=0, stall_cycles=0 immediately; nstall=1, stall_cause=0 during and after reset.
REQ-029 Reset mid-stall SHALL discard all pending branch/jalr tracking.

Configuration
REQ-030 Macro DISPATCH_STALL_PERF_EN defined: stall_cycles SHALL increment every clk where nstall==0, saturate at 32'hFFFF_FFFF, and clear on flush only via rst.
REQ-031 Macro undefined: stall_cycles SHALL be constant 0 and no counter register SHALL exist; all other behaviour identical.

Verification
REQ-032 MAX_BR=2: branch accepted on cycles 1,2 -> br_cnt=2, nstall=0, stall_cause=1; branch_solved cycle 5 -> br_cnt=1, nstall=1 cycle 6.
REQ-033 jalr accepted with br_cnt=1 -> WAIT_JALR, stall_cause=2; branch_solved during wait -> br_cnt=0, still stalled; jalr_solved -> nstall=1 next cycle.
REQ-034 branch and branch_solved same cycle at br_cnt=1 -> br_cnt stays 1; branch_solved at br_cnt=0 -> stays 0.
REQ-035 flush while WAIT_JALR, br_cnt=2, RECOVER_CYC=2 -> br_cnt=0, stall_cause=3 for 2 cycles, then nstall=1 if ifq_empty=0.
REQ-036 ifq_empty high 3 cycles in NORMAL -> WAIT_IFQ, nstall=0 until first cycle after ifq_empty falls.
REQ-037 With DISPATCH_STALL_PERF_EN: 7 stalled cycles -> stall_cycles=7; rst asserted mid-stall -> all outputs to reset values same cycle.

Source files
------------

// File: rtl/dispatch_stall_ctrl.sv
// Dispatch stall controller: gates dispatch on branch depth, a pending JALR, an empty fetch
// queue and post-flush recovery. Define DISPATCH_STALL_PERF_EN to build the stall-cycle counter.
module dispatch_stall_ctrl #(
    parameter int MAX_BR      = 2,
    parameter int RECOVER_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch,
    input  logic        jalr,
    input  logic        branch_solved,
    input  logic        jalr_solved,
    input  logic        ifq_empty,
    input  logic        flush,
    output logic        nstall,
    output logic [1:0]  stall_cause,
    output logic [3:0]  br_cnt,
    output logic [31:0] stall_cycles
);

    localparam logic [1:0] NORMAL    = 2'd0;
    localparam logic [1:0] WAIT_JALR = 2'd1;
    localparam logic [1:0] WAIT_IFQ  = 2'd2;
    localparam logic [1:0] RECOVER   = 2'd3;

    localparam logic [3:0] MAX_BR_C = 4'(MAX_BR);
    localparam logic [3:0] RC_INIT  = 4'(RECOVER_CYC - 1);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [3:0] rc;
    logic [3:0] rc_nxt;
    logic [3:0] br_nxt;
    logic       accept_br;
    logic       accept_jalr;
    logic       dec_br;

    assign nstall      = (state == NORMAL) && (br_cnt < MAX_BR_C);
    assign accept_br   = branch & nstall;
    assign accept_jalr = jalr & nstall;
    // A resolve with nothing in flight is dropped so the counter cannot wrap.
    assign dec_br      = branch_solved && (br_cnt != 4'd0);

    always_comb begin
        state_nxt = state;
        rc_nxt    = rc;
        br_nxt    = br_cnt;

        if (accept_br && !dec_br) begin
            br_nxt = br_cnt + 4'd1;
        end else if (!accept_br && dec_br) begin
            br_nxt = br_cnt - 4'd1;
        end

        case (state)
            NORMAL: begin
                if (accept_jalr) begin
                    state_nxt = WAIT_JALR;
                end else if (ifq_empty) begin
                    state_nxt = WAIT_IFQ;
                end
            end
            WAIT_JALR: begin
                if (jalr_solved) begin
                    state_nxt = NORMAL;
                end
            end
            WAIT_IFQ: begin
                if (!ifq_empty) begin
                    state_nxt = NORMAL;
                end
            end
            default: begin
                if (rc == 4'd0) begin
                    state_nxt = ifq_empty ? WAIT_IFQ : NORMAL;
                end else begin
                    rc_nxt = rc - 4'd1;
                end
            end
        endcase

        // Flush wins over everything, including a flush already in recovery.
        if (flush) begin
            state_nxt = RECOVER;
            rc_nxt    = RC_INIT;
            br_nxt    = 4'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= NORMAL;
            rc     <= 4'd0;
            br_cnt <= 4'd0;
        end else begin
            state  <= state_nxt;
            rc     <= rc_nxt;
            br_cnt <= br_nxt;
        end
    end

    always_comb begin
        if (state == RECOVER || state == WAIT_IFQ) begin
            stall_cause = 2'd3;
        end else if (state == WAIT_JALR) begin
            stall_cause = 2'd2;
        end else if (br_cnt == MAX_BR_C) begin
            stall_cause = 2'd1;
        end else begin
            stall_cause = 2'd0;
        end
    end

`ifdef DISPATCH_STALL_PERF_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 32'd0;
        end else if (!nstall && stall_cnt != 32'hFFFF_FFFF) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_dispatch_stall_ctrl.sv
// Bench for dispatch_stall_ctrl: directed stimulus, a per-cycle comparison against an
// abstract model of the stall rules, and literal spot checks of the headline scenarios.
module tb_dispatch_stall_ctrl;

    localparam int MAX_BR      = 2;
    localparam int RECOVER_CYC = 2;
`ifdef DISPATCH_STALL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        branch = 1'b0;
    logic        jalr = 1'b0;
    logic        branch_solved = 1'b0;
    logic        jalr_solved = 1'b0;
    logic        ifq_empty = 1'b0;
    logic        flush = 1'b0;
    logic        nstall;
    logic [1:0]  stall_cause;
    logic [3:0]  br_cnt;
    logic [31:0] stall_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    dispatch_stall_ctrl #(.MAX_BR(MAX_BR), .RECOVER_CYC(RECOVER_CYC)) dut (
        .clk(clk), .rst(rst), .branch(branch), .jalr(jalr),
        .branch_solved(branch_solved), .jalr_solved(jalr_solved),
        .ifq_empty(ifq_empty), .flush(flush), .nstall(nstall),
        .stall_cause(stall_cause), .br_cnt(br_cnt), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Abstract model: outstanding branches, what dispatch is waiting on, recovery cycles left.
    int     m_br = 0;
    bit     m_wait_jalr = 1'b0;
    bit     m_wait_ifq = 1'b0;
    int     m_recover_left = 0;
    longint m_stalls = 0;
    bit     m_ok;
    bit     m_had_br;

    function automatic bit model_ok();
        return !m_wait_jalr && !m_wait_ifq && (m_recover_left == 0) && (m_br < MAX_BR);
    endfunction

    function automatic int model_cause();
        if (m_recover_left != 0 || m_wait_ifq) return 3;
        if (m_wait_jalr) return 2;
        if (m_br == MAX_BR) return 1;
        return 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_br = 0; m_wait_jalr = 0; m_wait_ifq = 0; m_recover_left = 0; m_stalls = 0;
        end else begin
            m_ok = model_ok();
            m_had_br = (m_br > 0);
            if (!m_ok && PERF && m_stalls < 64'hFFFF_FFFF) m_stalls = m_stalls + 1;
            if (flush) begin
                // Recovery lasts RECOVER_CYC cycles, counted as cycles remaining.
                m_br = 0; m_wait_jalr = 0; m_wait_ifq = 0; m_recover_left = RECOVER_CYC;
            end else begin
                if (branch && m_ok) m_br = m_br + 1;
                if (branch_solved && m_had_br) m_br = m_br - 1;
                if (m_recover_left != 0) begin
                    m_recover_left = m_recover_left - 1;
                    if (m_recover_left == 0) m_wait_ifq = ifq_empty;
                end else if (m_wait_jalr) begin
                    if (jalr_solved) m_wait_jalr = 0;
                end else if (m_wait_ifq) begin
                    if (!ifq_empty) m_wait_ifq = 0;
                end else if (jalr && m_ok) begin
                    m_wait_jalr = 1;
                end else if (ifq_empty) begin
                    m_wait_ifq = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("model_nstall", nstall, model_ok());
        chk("model_cause", stall_cause, model_cause());
        chk("model_br_cnt", br_cnt, m_br);
        chk("model_stall_cycles", stall_cycles, m_stalls);
    end

    task automatic apply(input logic b, input logic j, input logic bs, input logic js,
                         input logic ie, input logic fl);
        branch = b; jalr = j; branch_solved = bs; jalr_solved = js;
        ifq_empty = ie; flush = fl;
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        apply(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_nstall", nstall, 1);
        chk("reset_cause", stall_cause, 0);
        chk("reset_br_cnt", br_cnt, 0);
        chk("reset_stall_cycles", stall_cycles, 0);
        rst = 1'b0;

        // Branch limit reached, then one resolve frees a slot.
        apply(1, 0, 0, 0, 0, 0);
        chk("br1_cnt", br_cnt, 1);
        apply(1, 0, 0, 0, 0, 0);
        chk("br2_cnt", br_cnt, 2);
        chk("br2_nstall", nstall, 0);
        chk("br2_cause", stall_cause, 1);
        idle();
        idle();
        apply(1, 0, 1, 0, 0, 0);
        chk("solve_cnt", br_cnt, 1);
        chk("solve_nstall", nstall, 1);
        chk("solve_cause", stall_cause, 0);

        // Simultaneous dispatch+resolve, and resolve at zero.
        apply(1, 0, 1, 0, 0, 0);
        chk("same_cycle_cnt", br_cnt, 1);
        apply(0, 0, 1, 0, 0, 0);
        apply(0, 0, 1, 0, 0, 0);
        chk("underflow_cnt", br_cnt, 0);

        // JALR wait with a branch resolving underneath.
        apply(1, 0, 0, 0, 0, 0);
        apply(0, 1, 0, 0, 0, 0);
        chk("jalr_cause", stall_cause, 2);
        chk("jalr_nstall", nstall, 0);
        chk("jalr_cnt", br_cnt, 1);
        apply(0, 0, 1, 0, 0, 0);
        chk("jalr_solve_cnt", br_cnt, 0);
        chk("jalr_still_stall", nstall, 0);
        apply(1, 0, 0, 0, 0, 0);
        chk("jalr_br_ignored", br_cnt, 0);
        apply(0, 0, 0, 1, 0, 0);
        chk("jalr_done_nstall", nstall, 1);

        // Branch and JALR together, then flush from WAIT_JALR at the limit.
        apply(1, 1, 0, 0, 0, 0);
        chk("both_cnt", br_cnt, 1);
        chk("both_cause", stall_cause, 2);
        apply(0, 0, 0, 1, 0, 0);
        apply(1, 1, 0, 0, 0, 0);
        chk("pre_flush_cnt", br_cnt, 2);
        chk("pre_flush_cause", stall_cause, 2);
        apply(0, 0, 0, 0, 0, 1);
        chk("flush_cnt", br_cnt, 0);
        chk("flush_cause_1", stall_cause, 3);
        idle();
        chk("flush_cause_2", stall_cause, 3);
        idle();
        chk("flush_done_nstall", nstall, 1);
        chk("flush_done_cause", stall_cause, 0);

        // Flush during recovery restarts it; recovery ending on empty IFQ goes to WAIT_IFQ.
        apply(0, 0, 0, 0, 0, 1);
        idle();
        apply(0, 0, 0, 0, 0, 1);
        idle();
        chk("restart_cause", stall_cause, 3);
        apply(0, 0, 0, 0, 1, 0);
        chk("rec_to_ifq_cause", stall_cause, 3);
        apply(0, 0, 0, 0, 0, 0);
        chk("rec_ifq_release", nstall, 1);

        // Empty fetch queue for three cycles.
        apply(0, 0, 0, 0, 1, 0);
        chk("ifq_stall_1", nstall, 0);
        apply(0, 0, 0, 0, 1, 0);
        apply(0, 0, 0, 0, 1, 0);
        chk("ifq_stall_3", nstall, 0);
        chk("ifq_cause", stall_cause, 3);
        apply(0, 0, 0, 0, 0, 0);
        chk("ifq_release", nstall, 1);

        // Flush beats a same-cycle branch.
        apply(1, 0, 0, 0, 0, 1);
        chk("flush_vs_branch", br_cnt, 0);
        idle();
        idle();

        // Stall counting from a clean reset.
        #1 rst = 1'b1;
        #1;
        @(posedge clk);
        #2 rst = 1'b0;
        apply(0, 0, 0, 0, 1, 0);
        repeat (7) apply(0, 0, 0, 0, 1, 0);
        chk("perf_7", stall_cycles, PERF ? 7 : 0);
        apply(0, 0, 0, 0, 0, 0);
        apply(1, 1, 0, 0, 0, 0);
        chk("pre_rst_cnt", br_cnt, 1);

        // Asynchronous reset in the middle of a JALR stall.
        #1 rst = 1'b1;
        #1;
        chk("async_rst_nstall", nstall, 1);
        chk("async_rst_cause", stall_cause, 0);
        chk("async_rst_cnt", br_cnt, 0);
        chk("async_rst_stalls", stall_cycles, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        idle();
        chk("post_rst_nstall", nstall, 1);
        chk("post_rst_cnt", br_cnt, 0);
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
